// File: rtl/vga_mem_arbiter.sv
// Single-port data-memory arbiter: shares one sync-read RAM between CPU loads/stores
// and VGA pixel prefetch, feeding a small pixel FIFO ahead of the VGA controller.
module vga_mem_arbiter #(
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       FIFO_DEPTH = 8,
  parameter int unsigned       LOW_WATER  = 2,
  parameter logic [ADDR_W-1:0] FB_BASE    = '0,
  parameter int unsigned       FB_WORDS   = 40000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [23:0]       pix_data,
  output logic              pix_valid,
  output logic              underflow,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned       PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned       CntW   = PtrW + 1;
  localparam logic [ADDR_W-1:0] FbLast = ADDR_W'(FB_BASE + FB_WORDS - 1);

  typedef enum logic [1:0] {CIdle, CWait, CDone} cpu_state_e;

  cpu_state_e        cpu_state_q, cpu_state_d;
  logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic              vga_inflight_q, vga_inflight_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic              underflow_q, underflow_d;
  logic [23:0]       fifo_q [FIFO_DEPTH];

  logic [CntW-1:0]   level;
  logic              vga_grant, cpu_grant;
  logic              push, pop, fifo_we;

  assign level = count_q + CntW'(vga_inflight_q);

  // Urgent VGA beats the CPU; otherwise VGA only takes slots the CPU leaves unused.
  always_comb begin
    vga_grant = 1'b0;
    cpu_grant = 1'b0;
    if (!reset) begin
      if (!frame_start && (level <= CntW'(LOW_WATER))) begin
        vga_grant = 1'b1;
      end else if (cpu_req && (cpu_state_q == CIdle)) begin
        cpu_grant = 1'b1;
      end else if (!frame_start && (level < CntW'(FIFO_DEPTH))) begin
        vga_grant = 1'b1;
      end
    end
  end

  always_comb begin
    mem_we    = cpu_grant & cpu_we;
    mem_wdata = cpu_wdata;
    if (vga_grant) begin
      mem_addr = fetch_ptr_q;
    end else if (cpu_grant) begin
      mem_addr = cpu_addr;
    end else begin
      mem_addr = addr_hold_q;
    end
    addr_hold_d = mem_addr;
  end

  always_comb begin
    cpu_state_d = cpu_state_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_stall   = 1'b0;
    unique case (cpu_state_q)
      CIdle: begin
        if (cpu_req) begin
          if (cpu_grant && cpu_we) begin
            cpu_stall = 1'b0;
          end else if (cpu_grant) begin
            cpu_stall   = 1'b1;
            cpu_state_d = CWait;
          end else begin
            cpu_stall = 1'b1;
          end
        end
      end
      CWait: begin
        cpu_stall   = 1'b1;
        cpu_rdata_d = mem_rdata;
        cpu_state_d = CDone;
      end
      CDone: begin
        cpu_state_d = CIdle;
      end
      default: begin
        cpu_state_d = CIdle;
      end
    endcase
    if (reset) begin
      cpu_stall = 1'b0;
    end
  end

  // Read data returning this cycle belongs to the VGA fetch issued last cycle.
  assign push    = vga_inflight_q;
  assign pop     = pix_pop && (count_q != '0);
  assign fifo_we = push && !frame_start && !reset;

  always_comb begin
    underflow_d    = underflow_q | (pix_pop && (count_q == '0));
    vga_inflight_d = vga_grant;
    fetch_ptr_d    = fetch_ptr_q;
    if (vga_grant) begin
      fetch_ptr_d = (fetch_ptr_q == FbLast) ? FB_BASE : fetch_ptr_q + ADDR_W'(1);
    end
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (frame_start) begin
      rd_ptr_d       = '0;
      wr_ptr_d       = '0;
      count_d        = '0;
      vga_inflight_d = 1'b0;
      fetch_ptr_d    = FB_BASE;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_state_q    <= CIdle;
      fetch_ptr_q    <= FB_BASE;
      addr_hold_q    <= FB_BASE;
      vga_inflight_q <= 1'b0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      cpu_rdata_q    <= '0;
      underflow_q    <= 1'b0;
    end else begin
      cpu_state_q    <= cpu_state_d;
      fetch_ptr_q    <= fetch_ptr_d;
      addr_hold_q    <= addr_hold_d;
      vga_inflight_q <= vga_inflight_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      cpu_rdata_q    <= cpu_rdata_d;
      underflow_q    <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_we) begin
      fifo_q[wr_ptr_q] <= mem_rdata[23:0];
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign pix_valid = (count_q != '0);
  assign pix_data  = pix_valid ? fifo_q[rd_ptr_q] : 24'h0;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: CPU access vector table, pixel-stream scoreboard and
// hand-written sequences for fill, starvation, frame_start flush and underflow.
module tb_vga_mem_arbiter;

  localparam int unsigned AW      = 16;
  localparam logic [15:0] FbBase  = 16'h0040;
  localparam int unsigned FbWords = 24;
  localparam logic [15:0] FbLast  = 16'h0057;

  logic        clk = 1'b0;
  logic        reset, cpu_req, cpu_we, cpu_stall, frame_start, pix_pop, pix_valid, underflow;
  logic        mem_we;
  logic [15:0] cpu_addr, mem_addr;
  logic [31:0] cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic [23:0] pix_data;

  always #5 clk = ~clk;

  vga_mem_arbiter #(
    .ADDR_W    (AW),
    .FIFO_DEPTH(8),
    .LOW_WATER (2),
    .FB_BASE   (FbBase),
    .FB_WORDS  (FbWords)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .frame_start(frame_start),
    .pix_pop    (pix_pop),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .underflow  (underflow),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stalls;
  } vec_t;

  vec_t        tbl [8];
  logic [31:0] exp_q [$];
  int          total = 0;
  int          bad = 0;
  int          exp_idx = 0;
  int          n_st;
  logic [15:0] exp_fetch;

  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h9E37_79B1 + 32'h0102_0304;
  endfunction

  function automatic logic [23:0] pix_of(input int idx);
    logic [31:0] w;
    w = init_word(int'(FbBase) + idx);
    return w[23:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RAM model: synchronous read of the pre-edge address, write-through on mem_we.
  logic [31:0] ram [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = init_word(i);
    ram[16'h0100] = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] = mem_wdata;
    end
  end

  // Pixel scoreboard: every accepted pop must present the next framebuffer word.
  always @(negedge clk) begin
    if (reset || frame_start) begin
      exp_idx = 0;
    end else if (pix_pop && pix_valid) begin
      chk("pixel", 32'(pix_data), 32'(pix_of(exp_idx)));
      exp_idx = (exp_idx + 1) % FbWords;
    end
  end

  task automatic cpu_access(input vec_t v);
    int stalls;
    bit done;
    cpu_req   = 1'b1;
    cpu_we    = v.we;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    if (!v.we) exp_q.push_back(v.rdata);
    stalls = 0;
    done   = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("cpu_mem_addr", 32'(mem_addr), 32'(v.addr));
        chk("cpu_mem_we", 32'(mem_we), 32'(v.we));
      end
      if (cpu_stall) stalls++;
      else done = 1'b1;
    end
    chk("cpu_done", 32'(done), 32'd1);
    chk("cpu_stalls", 32'(stalls), 32'(v.stalls));
    if (!v.we && exp_q.size() > 0) chk("cpu_rdata", cpu_rdata, exp_q.pop_front());
    tick();
    cpu_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 16'h0200, 32'h1111_2222, 32'h0, 0};
    tbl[1] = '{1'b1, 16'h0201, 32'h3333_4444, 32'h0, 0};
    tbl[2] = '{1'b0, 16'h0100, 32'h0, 32'hDEAD_BEEF, 2};
    tbl[3] = '{1'b0, 16'h0200, 32'h0, 32'h1111_2222, 2};
    tbl[4] = '{1'b0, 16'h0201, 32'h0, 32'h3333_4444, 2};
    tbl[5] = '{1'b1, 16'h0100, 32'hCAFE_F00D, 32'h0, 0};
    tbl[6] = '{1'b0, 16'h0100, 32'h0, 32'hCAFE_F00D, 2};
    tbl[7] = '{1'b0, 16'h0000, 32'h0, init_word(0), 2};

    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    frame_start = 1'b0; pix_pop = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_stall", 32'(cpu_stall), 32'h0);
    chk("rst_valid", 32'(pix_valid), 32'h0);
    chk("rst_data", 32'(pix_data), 32'h0);
    chk("rst_uflow", 32'(underflow), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'(FbBase));
    tick();
    reset = 1'b0;

    // Fill after reset: 8 fetches FB_BASE..+7, then idle holding the last address.
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("fill_addr", 32'(mem_addr), (c < 8) ? 32'(FbBase) + 32'(c) : 32'(FbBase) + 32'd7);
      chk("fill_we", 32'(mem_we), 32'h0);
      if (c < 2) chk("fill_valid_lo", 32'(pix_valid), 32'h0);
      if (c == 2) chk("fill_valid_hi", 32'(pix_valid), 32'h1);
      if (c == 11) chk("fill_head", 32'(pix_data), 32'(pix_of(0)));
      tick();
    end

    foreach (tbl[i]) cpu_access(tbl[i]);

    // Continuous stores with a pop every cycle: VGA must win whenever it is urgent.
    n_st = 0;
    exp_fetch = FbBase + 16'd7;
    pix_pop = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 16'h0300; cpu_wdata = 32'h5000_0000;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("st_valid", 32'(pix_valid), 32'h1);
      chk("st_uflow", 32'(underflow), 32'h0);
      if (!cpu_stall) begin
        chk("st_we", 32'(mem_we), 32'h1);
        chk("st_addr", 32'(mem_addr), 32'h0300 + 32'(n_st));
        n_st++;
      end else begin
        chk("vga_we", 32'(mem_we), 32'h0);
        exp_fetch = (exp_fetch == FbLast) ? FbBase : exp_fetch + 16'd1;
        chk("vga_addr", 32'(mem_addr), 32'(exp_fetch));
      end
      tick();
      cpu_addr  = 16'h0300 + 16'(n_st);
      cpu_wdata = 32'h5000_0000 + 32'(n_st);
    end
    chk("store_count", 32'(n_st), 32'd6);
    pix_pop = 1'b0; cpu_req = 1'b0;

    // Flush, refill to 5 entries with a read in flight, then flush again.
    frame_start = 1'b1;
    @(negedge clk);
    tick();
    frame_start = 1'b0;
    repeat (6) begin
      @(negedge clk);
      tick();
    end
    frame_start = 1'b1;
    @(negedge clk);
    chk("fs_pre_valid", 32'(pix_valid), 32'h1);
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    chk("fs_valid0", 32'(pix_valid), 32'h0);
    chk("fs_addr", 32'(mem_addr), 32'(FbBase));
    tick();
    @(negedge clk);
    chk("fs_valid1", 32'(pix_valid), 32'h0);
    tick();
    @(negedge clk);
    chk("fs_valid2", 32'(pix_valid), 32'h1);
    chk("fs_head", 32'(pix_data), 32'(pix_of(0)));
    tick();
    pix_pop = 1'b1;
    repeat (10) begin
      @(negedge clk);
      tick();
    end
    pix_pop = 1'b0;

    // Reset in the middle of a load abandons it.
    repeat (12) begin
      @(negedge clk);
      tick();
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    @(negedge clk);
    chk("rml_stall", 32'(cpu_stall), 32'h1);
    tick();
    reset = 1'b1; cpu_req = 1'b0;
    tick();
    @(negedge clk);
    chk("rml_rdata", cpu_rdata, 32'h0);
    chk("rml_stall0", 32'(cpu_stall), 32'h0);
    chk("rml_valid", 32'(pix_valid), 32'h0);
    chk("rml_addr", 32'(mem_addr), 32'(FbBase));
    tick();
    reset = 1'b0; pix_pop = 1'b1;

    // Pop on an empty FIFO sets the sticky underflow flag.
    @(negedge clk);
    chk("uf_before", 32'(underflow), 32'h0);
    tick();
    pix_pop = 1'b0;
    @(negedge clk);
    chk("uf_set", 32'(underflow), 32'h1);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    chk("uf_after_fs", 32'(underflow), 32'h1);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("uf_cleared", 32'(underflow), 32'h0);
    tick();
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_mem_arbiter.md
# vga_mem_arbiter

Single-port data-memory arbiter and scanout sequencer that sits between the pipeline's Memory stage, the VGA controller, and one synchronous-read RAM. It grants one memory slot per cycle to either the CPU load/store or a VGA pixel prefetch, stalls the CPU when it loses, and keeps a small pixel FIFO ahead of the VGA controller so scanout never starves. It replaces the dual-port data memory used for VGA readback.

## Interface
Parameters:
- ADDR_W, 16, memory word-address width
- FIFO_DEPTH, 8, pixel FIFO entries (power of two, ≥4)
- LOW_WATER, 2, occupancy at or below which VGA becomes urgent
- FB_BASE, 16'h0000, first framebuffer word address
- FB_WORDS, 40000, framebuffer length in words (one pixel per word)

Ports:
- clk  in  1  system clock (single clock domain)
- reset  in  1  synchronous, active-high
- cpu_req  in  1  Memory-stage access valid
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data (registered)
- cpu_stall  out  1  hold Memory stage
- frame_start  in  1  one-cycle pulse at start of frame
- pix_pop  in  1  VGA consumes head pixel
- pix_data  out  24  head pixel {B,G,R} = word[23:0]
- pix_valid  out  1  FIFO non-empty
- underflow  out  1  sticky: pop seen while empty
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, 1-cycle latency

## Operation
- Level = FIFO occupancy + VGA reads in flight (0 or 1); never exceeds FIFO_DEPTH.
- Slot grant each cycle, priority order: (1) VGA if level ≤ LOW_WATER; (2) CPU if cpu_req and CPU FSM in C_IDLE; (3) VGA if level < FIFO_DEPTH; (4) idle (mem_we=0, mem_addr holds).
- VGA grant: mem_addr = fetch pointer; pointer increments, wraps FB_BASE+FB_WORDS-1 → FB_BASE; tag in-flight as VGA.
- CPU FSM: C_IDLE, C_WAIT, C_DONE.
  - C_IDLE, store granted: mem_we=1, cpu_stall=0, stay C_IDLE.
  - C_IDLE, load granted: cpu_stall=1, → C_WAIT.
  - C_WAIT: capture mem_rdata into cpu_rdata at cycle end, cpu_stall=1, → C_DONE; slot free for VGA.
  - C_DONE: cpu_stall=0 (access completes this edge), no CPU issue, → C_IDLE.
  - cpu_req not granted in C_IDLE: cpu_stall=1.
  - cpu_req=0: cpu_stall=0.
- VGA read data written into FIFO the cycle after issue.
- pix_pop with pix_valid: head advances. Simultaneous pop and fill: occupancy unchanged.
- pix_pop while empty: ignored; underflow set, cleared only by reset.
- frame_start: FIFO emptied, pointer = FB_BASE, any in-flight VGA read discarded. Takes precedence over pop/fill that cycle. A CPU access in progress is unaffected.

## Timing
- Reset (sync): cpu_rdata=0, cpu_stall=0, pix_valid=0, pix_data=0, underflow=0, mem_we=0, mem_addr=FB_BASE, FSM=C_IDLE, pointer=FB_BASE, FIFO empty. Reset mid-load abandons it; no data returned.
- Store latency: 1 cycle if granted. Load: granted cycle t, cpu_stall high t and t+1, cpu_rdata valid from t+2 until next load.
- VGA fetch: issue t, pixel visible at FIFO head no earlier than t+2 (pix_valid rises t+2 if FIFO was empty).
- Grant, mem_* and cpu_stall combinational from state and inputs; FIFO and FSM update on posedge clk.
- Sustained CPU stores cannot starve VGA: urgent rule wins whenever level ≤ LOW_WATER.

## Test plan
- Reset, no pops, cpu_req=0 -> 8 reads at FB_BASE..+7, then idle; pix_valid=1, pix_data=mem[FB_BASE][23:0].
- Full FIFO, CPU load addr 0x0100 (RAM 0xDEADBEEF) -> cpu_stall 1,1,0; cpu_rdata=0xDEADBEEF third cycle; exactly one mem access at 0x0100.
- Continuous CPU stores while pix_pop every cycle -> level never below 1 after fill, underflow stays 0, stores stall only on VGA-urgent cycles.
- Pointer at FB_BASE+FB_WORDS-1 -> next VGA fetch at FB_BASE.
- frame_start with VGA read in flight and 5 entries -> pix_valid=0 next cycle, discarded data never appears, next fetch at FB_BASE.
- pix_pop while empty after reset -> underflow=1, stays 1 through frame_start, clears on reset.
